// File: rtl/signed_sub_with_overflow_serial_if.sv
// Operand/result bundle for the serial signed subtractor.
// Latency: none, wires only.
// Backpressure: arg_vld/arg_rdy on the operand side, res_vld/res_rdy on the result side.
// Signals: arg_vld, arg_rdy, a, b (operand side); res_vld, res_rdy, res, overflow (result side).
// master = producer/consumer side, slave = subtractor side.
interface signed_sub_with_overflow_serial_if #(
    parameter int WIDTH = 8
);
    logic             arg_vld;
    logic             arg_rdy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_vld;
    logic             res_rdy;
    logic [WIDTH-1:0] res;
    logic             overflow;

    modport master (
        output arg_vld, a, b, res_rdy,
        input  arg_rdy, res_vld, res, overflow
    );

    modport slave (
        input  arg_vld, a, b, res_rdy,
        output arg_rdy, res_vld, res, overflow
    );
endinterface

// File: rtl/signed_sub_with_overflow_serial.sv
// Serial two's-complement subtractor a - b with signed overflow flag, CHUNK bits per clock.
// Latency: N = WIDTH/CHUNK cycles from accept to res_vld; one operation per N+2 cycles.
// Backpressure: holds res/overflow/res_vld while res_rdy=0; accepts operands only when idle.
// Ports: clk, rst (synchronous, active-high), bus (slave modport of signed_sub_with_overflow_serial_if).
module signed_sub_with_overflow_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic                              clk,
    input logic                              rst,
    signed_sub_with_overflow_serial_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;       // minuend, shifted right one chunk per step
    logic [WIDTH-1:0] nb_sh;      // inverted subtrahend, shifted the same way
    logic             a_sign;     // operand sign bits kept for the overflow rule,
    logic             b_sign;     // since the shifters lose their MSBs
    logic             carry;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] res_q;
    logic             ovf_q;
    logic             arg_rdy_q;
    logic             res_vld_q;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] res_nxt;

    // One chunk of a + ~b + carry. The result register fills from the top and
    // shifts down, so after N steps chunk 0 lands at bit 0.
    always_comb begin
        sum     = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, nb_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        res_nxt = (res_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            nb_sh     <= '0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            carry     <= 1'b0;
            k         <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            arg_rdy_q <= 1'b1;
            res_vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // arg_rdy is high in IDLE, so arg_vld alone completes the handshake.
                    if (bus.arg_vld) begin
                        a_sh      <= bus.a;
                        nb_sh     <= ~bus.b;
                        a_sign    <= bus.a[WIDTH-1];
                        b_sign    <= bus.b[WIDTH-1];
                        carry     <= 1'b1;
                        k         <= '0;
                        arg_rdy_q <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> CHUNK;
                    nb_sh <= nb_sh >> CHUNK;
                    carry <= sum[CHUNK];
                    res_q <= res_nxt;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        // sum[CHUNK-1] is the result sign bit produced by this last step.
                        ovf_q     <= (a_sign != b_sign) && (sum[CHUNK-1] != a_sign);
                        res_vld_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_rdy) begin
                        res_vld_q <= 1'b0;
                        arg_rdy_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.arg_rdy  = arg_rdy_q;
    assign bus.res_vld  = res_vld_q;
    assign bus.res      = res_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_signed_sub_with_overflow_serial.sv
// Bench for signed_sub_with_overflow_serial: 8/2 instance for directed vectors and
// corner sequences, plus 4/1, 4/2, 4/4 instances for an exhaustive sweep with stalls.
// Inputs are driven 1 time unit after the rising edge; handshakes are observed at the falling edge.
module tb_signed_sub_with_overflow_serial;
    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // main 8-bit, 2-bit-chunk instance
    signed_sub_with_overflow_serial_if #(.WIDTH(8)) m_if ();
    signed_sub_with_overflow_serial #(.WIDTH(8), .CHUNK(2)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    // 4-bit sweep instances, CHUNK = 1, 2, 4
    logic       s_arg_vld [3];
    logic       s_arg_rdy [3];
    logic [3:0] s_a       [3];
    logic [3:0] s_b       [3];
    logic       s_res_vld [3];
    logic       s_res_rdy [3];
    logic [3:0] s_res     [3];
    logic       s_ovf     [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        signed_sub_with_overflow_serial_if #(.WIDTH(4)) bus ();
        signed_sub_with_overflow_serial #(.WIDTH(4), .CHUNK(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.arg_vld  = s_arg_vld[g];
        assign bus.a        = s_a[g];
        assign bus.b        = s_b[g];
        assign bus.res_rdy  = s_res_rdy[g];
        assign s_arg_rdy[g] = bus.arg_rdy;
        assign s_res_vld[g] = bus.res_vld;
        assign s_res[g]     = bus.res;
        assign s_ovf[g]     = bus.overflow;
    end

    exp_t m_q [$];
    exp_t sq  [3][$];
    exp_t m_pend;
    int   m_acc = 0;
    int   m_got = 0;
    int   s_idx [3];
    int   s_got [3];

    // Reference: exact integer difference, wrapped and range-checked.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
        int   ia;
        int   ib;
        int   d;
        exp_t e;
        ia = int'(a);
        ib = int'(b);
        if (a[w-1]) ia = ia - (1 << w);
        if (b[w-1]) ib = ib - (1 << w);
        d     = ia - ib;
        e.res = 8'(d & ((1 << w) - 1));
        e.ovf = (d > (1 << (w - 1)) - 1) || (d < -(1 << (w - 1)));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_vec++;
        n_bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Scoreboard: push on an operand handshake, pop and compare on a result handshake.
    task automatic observe();
        exp_t e;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < 3; i++) sq[i].delete();
            return;
        end
        if (m_if.arg_vld && m_if.arg_rdy) begin
            m_q.push_back(m_pend);
            m_acc++;
        end
        if (m_if.res_vld && m_if.res_rdy) begin
            m_got++;
            if (m_q.size() == 0) begin
                fail("main_spurious", $sformatf("result %0h with nothing outstanding", m_if.res));
            end else begin
                e = m_q.pop_front();
                chk("main_res", 32'(m_if.res), 32'(e.res));
                chk("main_ovf", 32'(m_if.overflow), 32'(e.ovf));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (s_arg_vld[i] && s_arg_rdy[i]) begin
                sq[i].push_back(model(4, {4'b0, s_a[i]}, {4'b0, s_b[i]}));
                s_idx[i]++;
            end
            if (s_res_vld[i] && s_res_rdy[i]) begin
                s_got[i]++;
                if (sq[i].size() == 0) begin
                    fail($sformatf("sweep%0d_spurious", i), "result with nothing outstanding");
                end else begin
                    e = sq[i].pop_front();
                    chk($sformatf("sweep%0d_res", i), 32'(s_res[i]), 32'(e.res[3:0]));
                    chk($sformatf("sweep%0d_ovf", i), 32'(s_ovf[i]), 32'(e.ovf));
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_main(input logic [7:0] a, input logic [7:0] b, input exp_t e, input string name);
        int acc0;
        int got0;
        int t;
        acc0         = m_acc;
        got0         = m_got;
        m_pend       = e;
        m_if.a       = a;
        m_if.b       = b;
        m_if.arg_vld = 1'b1;
        t = 0;
        while (m_acc == acc0 && t < 20) begin
            cycle();
            t++;
        end
        m_if.arg_vld = 1'b0;
        // operands must have been captured at the accept edge
        m_if.a = 8'($urandom);
        m_if.b = 8'($urandom);
        if (m_acc == acc0) fail(name, "operands never accepted");
        t = 0;
        while (m_got == got0 && t < 40) begin
            cycle();
            t++;
        end
        if (m_got == got0) fail(name, "no result within 40 cycles");
    endtask

    function automatic bit sweep_done();
        for (int i = 0; i < 3; i++) begin
            if (s_got[i] < 256) return 1'b0;
        end
        return 1'b1;
    endfunction

    vec_t vecs [11];

    initial begin
        int lat;
        int seen;
        int got0;
        int cyc;

        vecs[0]  = '{a: 8'h05, b: 8'h03, res: 8'h02, ovf: 1'b0};
        vecs[1]  = '{a: 8'h80, b: 8'h01, res: 8'h7F, ovf: 1'b1};
        vecs[2]  = '{a: 8'h7F, b: 8'hFF, res: 8'h80, ovf: 1'b1};
        vecs[3]  = '{a: 8'h00, b: 8'h80, res: 8'h80, ovf: 1'b1};
        vecs[4]  = '{a: 8'h80, b: 8'h80, res: 8'h00, ovf: 1'b0};
        vecs[5]  = '{a: 8'hFF, b: 8'h7F, res: 8'h80, ovf: 1'b0};
        vecs[6]  = '{a: 8'h03, b: 8'h05, res: 8'hFE, ovf: 1'b0};
        vecs[7]  = '{a: 8'h64, b: 8'h9C, res: 8'hC8, ovf: 1'b1};
        vecs[8]  = '{a: 8'h9C, b: 8'h64, res: 8'h38, ovf: 1'b1};
        vecs[9]  = '{a: 8'h12, b: 8'h34, res: 8'hDE, ovf: 1'b0};
        vecs[10] = '{a: 8'h7F, b: 8'h7F, res: 8'h00, ovf: 1'b0};

        rst          = 1'b1;
        m_if.arg_vld = 1'b0;
        m_if.a       = '0;
        m_if.b       = '0;
        m_if.res_rdy = 1'b1;
        m_pend       = '0;
        for (int i = 0; i < 3; i++) begin
            s_arg_vld[i] = 1'b0;
            s_a[i]       = '0;
            s_b[i]       = '0;
            s_res_rdy[i] = 1'b0;
            s_idx[i]     = 0;
            s_got[i]     = 0;
        end
        repeat (2) cycle();
        rst = 1'b0;

        // reset state
        chk("rst_arg_rdy", 32'(m_if.arg_rdy), 32'd1);
        chk("rst_res_vld", 32'(m_if.res_vld), 32'd0);
        chk("rst_res", 32'(m_if.res), 32'd0);
        chk("rst_ovf", 32'(m_if.overflow), 32'd0);

        // basic 5 - 3 with latency and ready timing
        m_if.a       = 8'd5;
        m_if.b       = 8'd3;
        m_pend       = model(8, 8'd5, 8'd3);
        m_if.arg_vld = 1'b1;
        cycle();
        m_if.arg_vld = 1'b0;
        chk("basic_arg_rdy_low", 32'(m_if.arg_rdy), 32'd0);
        lat = 0;
        while (!m_if.res_vld && lat < 20) begin
            cycle();
            lat++;
        end
        chk("basic_latency", 32'(lat), 32'd4);
        chk("basic_arg_rdy_busy", 32'(m_if.arg_rdy), 32'd0);
        cycle();
        chk("basic_arg_rdy_back", 32'(m_if.arg_rdy), 32'd1);
        chk("basic_res_vld_drop", 32'(m_if.res_vld), 32'd0);
        chk("basic_res_held", 32'(m_if.res), 32'h02);

        // directed table
        for (int i = 0; i < 11; i++) begin
            run_main(vecs[i].a, vecs[i].b, '{res: vecs[i].res, ovf: vecs[i].ovf}, $sformatf("vec%0d", i));
        end

        // backpressure: result held 5 cycles, stray operands ignored
        m_if.res_rdy = 1'b0;
        m_if.a       = 8'h40;
        m_if.b       = 8'h10;
        m_pend       = '{res: 8'h30, ovf: 1'b0};
        m_if.arg_vld = 1'b1;
        cycle();
        m_if.arg_vld = 1'b0;
        lat = 0;
        while (!m_if.res_vld && lat < 20) begin
            cycle();
            lat++;
        end
        chk("bp_res_vld", 32'(m_if.res_vld), 32'd1);
        got0 = m_got;
        for (int c = 0; c < 5; c++) begin
            m_if.arg_vld = (c == 2);
            m_if.a       = 8'h01;
            m_if.b       = 8'h02;
            cycle();
            chk("bp_hold_vld", 32'(m_if.res_vld), 32'd1);
            chk("bp_hold_res", 32'(m_if.res), 32'h30);
            chk("bp_hold_ovf", 32'(m_if.overflow), 32'd0);
            chk("bp_arg_rdy", 32'(m_if.arg_rdy), 32'd0);
        end
        m_if.arg_vld = 1'b0;
        m_if.res_rdy = 1'b1;
        repeat (8) cycle();
        chk("bp_one_result", 32'(m_got - got0), 32'd1);
        chk("bp_idle_vld", 32'(m_if.res_vld), 32'd0);

        // reset while BUSY at chunk 2
        m_if.a       = 8'h11;
        m_if.b       = 8'h22;
        m_pend       = model(8, 8'h11, 8'h22);
        m_if.arg_vld = 1'b1;
        cycle();
        m_if.arg_vld = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_arg_rdy", 32'(m_if.arg_rdy), 32'd1);
        chk("midrst_res_vld", 32'(m_if.res_vld), 32'd0);
        seen = 0;
        repeat (8) begin
            cycle();
            if (m_if.res_vld) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run_main(8'd7, 8'd9, '{res: 8'hFE, ovf: 1'b0}, "post_rst");

        // exhaustive 4-bit sweep on all three chunk sizes with random stalls
        cyc = 0;
        while (!sweep_done() && cyc < 20000) begin
            for (int i = 0; i < 3; i++) begin
                s_arg_vld[i] = (s_idx[i] < 256);
                s_a[i]       = 4'(s_idx[i] >> 4);
                s_b[i]       = 4'(s_idx[i]);
                s_res_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            s_arg_vld[i] = 1'b0;
            chk($sformatf("sweep%0d_count", i), 32'(s_got[i]), 32'd256);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/signed_sub_with_overflow_serial.md
# signed_sub_with_overflow_serial

Multi-cycle signed (two's complement) subtractor computing `a - b` with overflow detection. It processes `CHUNK` bits per clock, LSB chunk first, carrying the borrow between cycles. It is the subtract counterpart of the combinational signed adder in the arithmetics/pipelining section. Valid/ready handshakes on both sides let it sit between a producer and a consumer that can stall.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `CHUNK`, default 2: bits processed per cycle. `WIDTH % CHUNK == 0`. `N = WIDTH / CHUNK`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `arg_vld`  in  1  operands valid.
- `arg_rdy`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend, signed.
- `b`  in  WIDTH  subtrahend, signed.
- `res_vld`  out  1  result valid.
- `res_rdy`  in  1  consumer accepts result.
- `res`  out  WIDTH  `a - b` modulo 2^WIDTH.
- `overflow`  out  1  true result does not fit in signed WIDTH bits.

## Operation
- States:
  - IDLE: `arg_rdy=1`.
  - BUSY: chunk counter 0..N-1.
  - DONE: `res_vld=1`.
  - `arg_rdy` and `res_vld` are decoded from state only, with no combinational path from `arg_vld` or `res_rdy`.
- IDLE → BUSY on an edge with `arg_vld && arg_rdy`:
  - Latch `a` and `~b`.
  - Set carry to 1, so `a - b = a + ~b + 1`.
  - Clear the chunk counter.
- BUSY: each edge performs one step.
  - Compute `{carry, res[k*CHUNK +: CHUNK]} = a_chunk + nb_chunk + carry`.
  - Increment k.
  - After the step with k = N-1, go to DONE.
- Overflow is computed at the final step and registered with `res`: `overflow = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1])`.
- `res` is always the wrapped result, whether or not overflow is set.
- DONE → IDLE on an edge with `res_rdy`.
  - `res`, `overflow`, `res_vld` stay stable while `res_rdy=0`, for any number of cycles.
  - After the handshake, `res` and `overflow` keep their last values; only `res_vld` drops.
- No overlap: new operands are accepted only in IDLE. `arg_vld` in BUSY or DONE is ignored and operands are not sampled.
- Operands are sampled only at the accept edge. Changes to `a` and `b` afterwards do not affect the result.
- Reset at any point (IDLE, mid-BUSY, DONE with result pending):
  - State goes to IDLE.
  - The in-flight operation is discarded.
  - `res_vld` is 0 from the next cycle; the result is never presented.
- Reset values: state IDLE, `arg_rdy=1`, `res_vld=0`, `res=0`, `overflow=0`, carry 0, counter 0.

## Timing
- Accept at edge E0.
- BUSY steps occur at edges E0+1 … E0+N.
- `res_vld=1` in the cycle after edge E0+N. Latency from accept to result valid is N cycles after the accept cycle.
- With `res_rdy` held at 1, the handshake completes at edge E0+N+1, and `arg_rdy=1` from then on.
- Maximum throughput is one operation per N+2 cycles.
- With `CHUNK == WIDTH` (N=1), BUSY lasts exactly one cycle; there is no special case.
- `arg_rdy=0` from the cycle after E0 until the cycle after the result handshake edge.

## Test plan
- Basic subtract, WIDTH=8, CHUNK=2: `a=5`, `b=3`, `res_rdy=1`.
  - `res_vld` rises 4 cycles after accept.
  - `res=2`, `overflow=0`.
  - `arg_rdy` returns after 1 more edge.
- Overflow at both extremes:
  - `-128 - 1` → `res=127` (0x7F), `overflow=1`.
  - `127 - (-1)` → `res=-128` (0x80), `overflow=1`.
  - `0 - (-128)` → `res=-128`, `overflow=1`.
- No-overflow edge cases:
  - `-128 - (-128)` → `res=0`, `overflow=0`.
  - `-1 - 127` → `res=-128`, `overflow=0`.
  - `3 - 5` → `res=-2` (0xFE), `overflow=0`.
- Backpressure: hold `res_rdy=0` for 5 cycles after `res_vld`.
  - `res`, `overflow`, `res_vld` stay constant.
  - A second `arg_vld` pulse with new operands is ignored.
  - After `res_rdy=1`, exactly one result is delivered.
- Reset mid-BUSY: assert `rst` for one cycle at chunk k=2.
  - `res_vld` never rises for that operation.
  - `arg_rdy=1` the cycle after reset.
  - A subsequent `7 - 9` yields `res=-2`, `overflow=0`.
- Exhaustive sweep at WIDTH=4 for CHUNK=1, 2 and 4: all 256 operand pairs against the reference `a - b` wrap and the sign-rule overflow, with random `res_rdy` stalls.
